// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared constants and helpers for the output-stationary matmul
//               datapath: default operand/accumulator widths, default array
//               dimensions and the inner-dimension range check.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int MATMUL_DATA_W = 32;   // operand element width (unsigned)
    localparam int MATMUL_ACC_W  = 32;   // accumulator / C element width
    localparam int MATMUL_M      = 2;    // rows of A and C
    localparam int MATMUL_N      = 2;    // columns of B and C
    localparam int MATMUL_K      = 2;    // maximum inner dimension

    // True when inner index k addresses a real A column / B row.
    function automatic logic idx_ok(input int unsigned k, input int unsigned kmax);
        return (k < kmax);
    endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_datapath_if
// Description : Operand/result bundle between the matmul compute controller
//               and the MAC array.
//                 en    - perform one accumulate step at index k
//                 clear - zero all accumulators
//                 k     - inner-dimension index ($clog2(K)+1 bits)
//                 A     - operand matrix A [M][K]
//                 B     - operand matrix B [K][N]
//                 C     - registered accumulator matrix [M][N]
//               master : controller side (drives en/clear/k/A/B, reads C)
//               slave  : datapath side  (reads en/clear/k/A/B, drives C)
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_datapath_if
    import matmul_pkg::*;
#(
    parameter int DATA_W = MATMUL_DATA_W,
    parameter int ACC_W  = MATMUL_ACC_W,
    parameter int M      = MATMUL_M,
    parameter int N      = MATMUL_N,
    parameter int K      = MATMUL_K
);
    localparam int K_W = $clog2(K) + 1;

    logic              en;
    logic              clear;
    logic [K_W-1:0]    k;
    logic [DATA_W-1:0] A [M][K];
    logic [DATA_W-1:0] B [K][N];
    logic [ACC_W-1:0]  C [M][N];

    modport master (output en, clear, k, A, B, input  C);
    modport slave  (input  en, clear, k, A, B, output C);

endinterface : matmul_datapath_if
`default_nettype wire

// File: rtl/matmul_mac_cell.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac_cell
// Description : Single output-stationary multiply-accumulate cell.
//               Priority per edge: rst > clear > en > hold.
//               Default build wraps modulo 2^ACC_W. With MATMUL_DP_SAT_EN
//               defined, the product is clamped to 2^ACC_W-1 and the sum
//               saturates at 2^ACC_W-1.
// Ports       : clk, rst (async, active-high), i_clear, i_en,
//               i_a / i_b (operands), o_acc (registered accumulator)
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac_cell
    import matmul_pkg::*;
#(
    parameter int DATA_W = MATMUL_DATA_W,
    parameter int ACC_W  = MATMUL_ACC_W
)(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    input  wire logic              i_en,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output      logic [ACC_W-1:0]  o_acc
);
    localparam int PROD_W = 2 * DATA_W;
    // One guard bit above the wider of accumulator and product.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    logic [ACC_W-1:0]  r_acc;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_next;

    assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

`ifdef MATMUL_DP_SAT_EN
    localparam logic [SUM_W-1:0] c_acc_max = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    logic [SUM_W-1:0] w_prod_clamp;

    always_comb begin
        w_prod_clamp = (SUM_W'(w_prod) > c_acc_max) ? c_acc_max : SUM_W'(w_prod);
        w_sum        = SUM_W'(r_acc) + w_prod_clamp;
        w_next       = (w_sum > c_acc_max) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    end
`else
    always_comb begin
        w_sum  = SUM_W'(r_acc) + SUM_W'(w_prod);
        w_next = w_sum[ACC_W-1:0];
    end

    // Carry bits above ACC_W are discarded by the modulo wrap.
    logic w_unused_hi;
    assign w_unused_hi = ^w_sum[SUM_W-1:ACC_W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule : matmul_mac_cell
`default_nettype wire

// File: rtl/matmul_datapath.sv
`default_nettype none
// ============================================================================
// Module      : matmul_datapath
// Description : Output-stationary MxN MAC array computing C = A x B one
//               k-slice per cycle. Each cell (i,j) receives A[i][k] and
//               B[k][j]; out-of-range k (k >= K) leaves C unchanged.
//               Optional macro MATMUL_DP_SAT_EN selects saturating
//               accumulation instead of modulo wrap (no port change).
// Ports       : clk, rst (async, active-high),
//               bus (matmul_datapath_if.slave: en, clear, k, A, B -> C)
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_datapath
    import matmul_pkg::*;
#(
    parameter int DATA_W = MATMUL_DATA_W,
    parameter int ACC_W  = MATMUL_ACC_W,
    parameter int M      = MATMUL_M,
    parameter int N      = MATMUL_N,
    parameter int K      = MATMUL_K
)(
    input wire logic          clk,
    input wire logic          rst,
    matmul_datapath_if.slave  bus
);
    // Index width that exactly addresses K operand slices.
    localparam int KI_W = (K > 1) ? $clog2(K) : 1;

    logic              w_k_ok;
    logic [KI_W-1:0]   w_k_idx;
    logic              w_step_en;
    logic [DATA_W-1:0] w_a_sel [M];
    logic [DATA_W-1:0] w_b_sel [N];
    logic [ACC_W-1:0]  w_acc   [M][N];

    assign w_k_ok    = idx_ok(32'(bus.k), K);
    // Out-of-range k is steered to slice 0 so the mux never reads past the
    // array; the step itself is suppressed by w_step_en.
    assign w_k_idx   = w_k_ok ? bus.k[KI_W-1:0] : '0;
    assign w_step_en = bus.en & w_k_ok;

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_a_sel
            assign w_a_sel[gi] = bus.A[gi][w_k_idx];
        end

        for (genvar gj = 0; gj < N; gj++) begin : g_b_sel
            assign w_b_sel[gj] = bus.B[w_k_idx][gj];
        end

        for (genvar gi = 0; gi < M; gi++) begin : g_row
            for (genvar gj = 0; gj < N; gj++) begin : g_col
                matmul_mac_cell #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W)
                ) u_cell (
                    .clk     (clk),
                    .rst     (rst),
                    .i_clear (bus.clear),
                    .i_en    (w_step_en),
                    .i_a     (w_a_sel[gi]),
                    .i_b     (w_b_sel[gj]),
                    .o_acc   (w_acc[gi][gj])
                );

                assign bus.C[gi][gj] = w_acc[gi][gj];
            end
        end
    endgenerate

endmodule : matmul_datapath
`default_nettype wire

// File: tb/tb_matmul_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_datapath
// Description : Self-checking bench for matmul_datapath. Directed cases plus
//               randomized multiply sequences compared against a plain
//               arithmetic model of C = A x B. Honours MATMUL_DP_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_datapath;
    import matmul_pkg::*;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int M      = 2;
    localparam int N      = 2;
    localparam int K      = 2;
    localparam int K_W    = $clog2(K) + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    matmul_datapath_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .M(M), .N(N), .K(K)) bus ();

    matmul_datapath #(.DATA_W(DATA_W), .ACC_W(ACC_W), .M(M), .N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ACC_W-1:0]  exp_c [M][N];
    logic [DATA_W-1:0] op_a  [M][K];
    logic [DATA_W-1:0] op_b  [K][N];

    // One accumulate of a*b into acc, per the arithmetic rule.
    function automatic logic [ACC_W-1:0] ref_acc(input logic [ACC_W-1:0] acc,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        longint unsigned p, s, mx;
        mx = 64'h0000_0000_FFFF_FFFF;
        p  = 64'(a) * 64'(b);
`ifdef MATMUL_DP_SAT_EN
        if (p > mx) p = mx;
        s = 64'(acc) + p;
        if (s > mx) s = mx;
`else
        s = 64'(acc) + p;
`endif
        return ACC_W'(s);
    endfunction

    task automatic model_zero();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                exp_c[i][j] = '0;
    endtask

    task automatic apply_ops();
        for (int i = 0; i < M; i++)
            for (int kk = 0; kk < K; kk++)
                bus.A[i][kk] = op_a[i][kk];
        for (int kk = 0; kk < K; kk++)
            for (int j = 0; j < N; j++)
                bus.B[kk][j] = op_b[kk][j];
    endtask

    // Drive one clock with the given controls and advance the model.
    task automatic cycle(input logic en, input logic clr, input int kk);
        bus.en    = en;
        bus.clear = clr;
        bus.k     = K_W'(kk);
        @(posedge clk);
        #1;
        if (clr) begin
            model_zero();
        end else if (en && kk < K) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    exp_c[i][j] = ref_acc(exp_c[i][j], op_a[i][kk], op_b[kk][j]);
        end
        bus.en    = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_checks++;
                assert (bus.C[i][j] === exp_c[i][j]) else begin
                    n_fail++;
                    $error("FAIL %s C[%0d][%0d] observed=%h expected=%h",
                           tag, i, j, bus.C[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    task automatic check_one(input string tag, input int i, input int j,
                             input logic [ACC_W-1:0] want);
        n_checks++;
        assert (bus.C[i][j] === want) else begin
            n_fail++;
            $error("FAIL %s C[%0d][%0d] observed=%h expected=%h",
                   tag, i, j, bus.C[i][j], want);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] mask;
        int nk;

        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.clear = 1'b0;
        bus.k     = '0;
        for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) op_a[i][kk] = '0;
        for (int kk = 0; kk < K; kk++) for (int j = 0; j < N; j++) op_b[kk][j] = '0;
        apply_ops();
        model_zero();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_c("reset_state");
        rst = 1'b0;

        // Basic 2x2x2 with partial-K checkpoint after k=0.
        op_a[0][0] = 1; op_a[0][1] = 2; op_a[1][0] = 3; op_a[1][1] = 4;
        op_b[0][0] = 5; op_b[0][1] = 6; op_b[1][0] = 7; op_b[1][1] = 8;
        apply_ops();
        cycle(1'b0, 1'b1, 0);
        check_c("clear");
        cycle(1'b1, 1'b0, 0);
        check_c("partial_k0");
        check_one("partial_k0_lit", 1, 1, 32'd18);
        cycle(1'b1, 1'b0, 1);
        check_c("basic_2x2x2");
        check_one("basic_lit00", 0, 0, 32'd19);
        check_one("basic_lit11", 1, 1, 32'd50);

        // Out-of-range k leaves C untouched.
        cycle(1'b1, 1'b0, 2);
        check_c("oor_k2");
        cycle(1'b1, 1'b0, 3);
        check_c("oor_k3");
        check_one("oor_lit10", 1, 0, 32'd43);

        // Idle hold for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0, 0);
            check_c("hold");
        end

        // Clear wins over en.
        cycle(1'b1, 1'b1, 0);
        check_c("clear_over_en");
        check_one("clear_over_en_lit", 0, 1, 32'd0);

        // Overflow of the accumulator.
        for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) op_a[i][kk] = '0;
        for (int kk = 0; kk < K; kk++) for (int j = 0; j < N; j++) op_b[kk][j] = '0;
        op_a[0][0] = 32'h0001_0000;
        op_b[0][0] = 32'h0001_0000;
        apply_ops();
        cycle(1'b0, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        check_c("overflow");
`ifdef MATMUL_DP_SAT_EN
        check_one("overflow_lit", 0, 0, 32'hFFFF_FFFF);
`else
        check_one("overflow_lit", 0, 0, 32'h0000_0000);
`endif

        // Randomized multiplies with interleaved idle and out-of-range steps.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(2))
                0:       mask = 32'h0000_000F;
                1:       mask = 32'h0000_FFFF;
                default: mask = 32'hFFFF_FFFF;
            endcase
            for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) op_a[i][kk] = $urandom & mask;
            for (int kk = 0; kk < K; kk++) for (int j = 0; j < N; j++) op_b[kk][j] = $urandom & mask;
            apply_ops();
            cycle(1'b0, 1'b1, 0);
            nk = $urandom_range(6, 1);
            for (int s = 0; s < nk; s++) begin
                cycle($urandom_range(3) != 0, 1'b0, $urandom_range(3));
                check_c("random");
            end
        end

        // Asynchronous reset mid-run with C nonzero.
        op_a[0][0] = 9; op_a[0][1] = 1; op_a[1][0] = 2; op_a[1][1] = 3;
        op_b[0][0] = 4; op_b[0][1] = 5; op_b[1][0] = 6; op_b[1][1] = 7;
        apply_ops();
        cycle(1'b0, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);
        check_c("pre_reset");
        #2;
        rst = 1'b1;
        #1;
        model_zero();
        check_c("async_reset");
        bus.en = 1'b1;
        bus.k  = '0;
        @(posedge clk); #1;
        check_c("reset_held");
        rst    = 1'b0;
        bus.en = 1'b0;
        cycle(1'b0, 1'b0, 0);
        check_c("after_reset");
        cycle(1'b1, 1'b0, 1);
        check_c("after_reset_step");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_matmul_datapath
`default_nettype wire
